passthru_checker: RTL and testbench
===================================

Name: passthru_checker

Overview:
Scoreboard stage directly downstream of the 32-bit pass-through word module. The stimulus side pushes each word it drives into the pass-through as an expected word; this block queues them. The pass-through output is sampled as observed words and compared in order against the queue head. The block counts matches and mismatches and raises a sticky error flag. It captures the first failing pair for debug.

Parameters:
WIDTH, 32, data width of expected and observed words
DEPTH, 8, expected-word queue depth (power of 2, >= 2)
CNT_W, 16, width of the match and mismatch counters

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
exp_valid  in  1  expected word offered
exp_ready  out  1  queue can accept; high when the queue is not full
exp_data  in  WIDTH  expected word
obs_valid  in  1  observed word present this cycle (no backpressure)
obs_data  in  WIDTH  observed pass-through output word
level  out  $clog2(DEPTH)+1  current queue occupancy
match_cnt  out  CNT_W  number of compares that matched
mismatch_cnt  out  CNT_W  number of compares that mismatched
unexpected  out  1  sticky; set when obs_valid arrives with the queue empty
error  out  1  sticky; set on any mismatch or unexpected observation
first_exp  out  WIDTH  expected word of the first failure
first_obs  out  WIDTH  observed word of the first failure
state  out  2  0=IDLE, 1=RUN, 2=FAIL

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset: all outputs are 0 except exp_ready, which is 1. Queue is emptied. state=IDLE. Reset overrides every other input in the same cycle.
- Push: on exp_valid && exp_ready the word is written at the tail. level increments next cycle unless a pop happens in the same cycle.
- exp_ready is computed from registered level only. When full, a push is refused even if a pop happens in the same cycle.
- Pop/compare: on obs_valid with level>0, the head is popped and compared with obs_data over the full WIDTH.
- Compare results are registered. Counters, error, first_* and state update on the clock edge ending the obs_valid cycle (1-cycle latency).
- No bypass: obs_valid with level==0 is unexpected, even if a push happens in the same cycle. Any same-cycle push is still accepted.
- Unexpected observation: no pop occurs and no counter increments. unexpected=1 and error=1.
- Simultaneous push and pop with 0<level<DEPTH: level is unchanged and the queue order is preserved.
- Pointers wrap modulo DEPTH. level ranges 0..DEPTH.
- Counters saturate at 2^CNT_W-1 and never wrap.
- first_exp/first_obs are loaded only on the first failure after reset and hold thereafter.
- For an unexpected observation, first_exp=0 and first_obs=obs_data.
- State machine:
  IDLE -> RUN on the first accepted push or first obs_valid.
  RUN -> FAIL on the first mismatch or unexpected observation.
  FAIL is absorbing until rst; compares and counting continue in FAIL.
  An unexpected observation while in IDLE goes straight to FAIL.
- Reset mid-operation: queue contents are discarded. A pending compare from the reset cycle is not counted.

Test Plan:
- Reset, then push 0x00000001, 0xDEADBEEF, 0xFFFFFFFF. Observe the same three words, one per cycle, starting the cycle after the last push -> match_cnt=3, mismatch_cnt=0, error=0, level=0, state=RUN.
- Push 0x12345678 and observe 0x12345679 -> mismatch_cnt=1 and error=1 one cycle later. first_exp=0x12345678, first_obs=0x12345679, state=FAIL. A second mismatch leaves first_* unchanged.
- Push DEPTH=8 words without observing -> level=8, exp_ready=0. A 9th push with a same-cycle observe is refused. Next cycle level=7 and exp_ready=1. Draining yields all 8 in order and match_cnt=8.
- obs_valid=1 with obs_data=0xA5A5A5A5, an empty queue and exp_valid=1 in the same cycle -> unexpected=1, error=1, first_obs=0xA5A5A5A5, level=1, match_cnt=0.
- Continuous push/observe of 20 words (wraps pointers twice) with level held at 3 -> match_cnt=20, no error. With CNT_W=4, 20 matches saturate match_cnt at 15.
- Assert rst while level=5 and state=FAIL -> next cycle level=0, all counters 0, error=0, state=IDLE. Push/observe then resumes normally.

Source files
------------

// File: rtl/passthru_checker.sv
// In-order scoreboard for a 32-bit pass-through: queues expected words, compares
// each observed word against the queue head, counts results and latches the first failure.
module passthru_checker #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exp_valid,
  output logic                     exp_ready,
  input  logic [WIDTH-1:0]         exp_data,
  input  logic                     obs_valid,
  input  logic [WIDTH-1:0]         obs_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         match_cnt,
  output logic [CNT_W-1:0]         mismatch_cnt,
  output logic                     unexpected,
  output logic                     error,
  output logic [WIDTH-1:0]         first_exp,
  output logic [WIDTH-1:0]         first_obs,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } state_t;

  state_t           st;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic             push_p0;
  logic             pop_p0;
  logic             unexp_p0;
  logic             miss_p0;
  logic             fail_p0;
  logic [WIDTH-1:0] head_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v)
      return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Stage p0: queue access and compare, all from registered occupancy
  assign exp_ready = (level != LW'(DEPTH));
  assign push_p0   = exp_valid && exp_ready;
  assign pop_p0    = obs_valid && (level != '0);
  assign unexp_p0  = obs_valid && (level == '0);
  assign head_p0   = mem[rd_ptr];
  assign miss_p0   = pop_p0 && (head_p0 != obs_data);
  assign fail_p0   = miss_p0 || unexp_p0;
  assign state     = st;

  always_ff @(posedge clk) begin
    if (push_p0)
      mem[wr_ptr] <= exp_data;
  end

  // Stage p1: registered results; reset discards the queue and any same-cycle compare
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      match_cnt    <= '0;
      mismatch_cnt <= '0;
      unexpected   <= 1'b0;
      error        <= 1'b0;
      first_exp    <= '0;
      first_obs    <= '0;
      st           <= IDLE;
    end else begin
      if (push_p0)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop_p0)
        rd_ptr <= rd_ptr + AW'(1);

      case ({push_p0, pop_p0})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (pop_p0 && !miss_p0)
        match_cnt <= sat_inc(match_cnt);
      if (miss_p0)
        mismatch_cnt <= sat_inc(mismatch_cnt);
      if (unexp_p0)
        unexpected <= 1'b1;

      if (fail_p0) begin
        error <= 1'b1;
        if (!error) begin
          first_exp <= unexp_p0 ? '0 : head_p0;
          first_obs <= obs_data;
        end
      end

      case (st)
        IDLE: begin
          if (fail_p0)
            st <= FAIL;
          else if (push_p0 || obs_valid)
            st <= RUN;
        end
        RUN: begin
          if (fail_p0)
            st <= FAIL;
        end
        FAIL:    st <= FAIL;
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_passthru_checker.sv
// Directed bench for passthru_checker: a queue-based scoreboard predicts every
// output after each clock; a CNT_W=4 copy shares the stimulus to exercise saturation.
module tb_passthru_checker;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             exp_valid;
  logic [WIDTH-1:0] exp_data;
  logic             obs_valid;
  logic [WIDTH-1:0] obs_data;

  logic             exp_ready;
  logic [3:0]       level;
  logic [15:0]      match_cnt;
  logic [15:0]      mismatch_cnt;
  logic             unexpected;
  logic             error;
  logic [WIDTH-1:0] first_exp;
  logic [WIDTH-1:0] first_obs;
  logic [1:0]       state;

  logic             s_exp_ready;
  logic [3:0]       s_level;
  logic [3:0]       s_match_cnt;
  logic [3:0]       s_mismatch_cnt;
  logic             s_unexpected;
  logic             s_error;
  logic [WIDTH-1:0] s_first_exp;
  logic [WIDTH-1:0] s_first_obs;
  logic [1:0]       s_state;

  always #5 clk = ~clk;

  passthru_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_data(exp_data),
    .obs_valid(obs_valid), .obs_data(obs_data),
    .level(level), .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt),
    .unexpected(unexpected), .error(error),
    .first_exp(first_exp), .first_obs(first_obs), .state(state)
  );

  passthru_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst),
    .exp_valid(exp_valid), .exp_ready(s_exp_ready), .exp_data(exp_data),
    .obs_valid(obs_valid), .obs_data(obs_data),
    .level(s_level), .match_cnt(s_match_cnt), .mismatch_cnt(s_mismatch_cnt),
    .unexpected(s_unexpected), .error(s_error),
    .first_exp(s_first_exp), .first_obs(s_first_obs), .state(s_state)
  );

  int               tests = 0;
  int               fails = 0;
  logic [WIDTH-1:0] q[$];
  int               m_match;
  int               m_mis;
  logic             m_unexp;
  logic             m_err;
  logic [WIDTH-1:0] m_fe;
  logic [WIDTH-1:0] m_fo;
  int               m_state;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, o, e);
    end
  endtask

  task automatic check_all();
    int sm;
    sm = (m_match > 15) ? 15 : m_match;
    chk("level",        32'(level),        32'(q.size()));
    chk("exp_ready",    32'(exp_ready),    (q.size() < DEPTH) ? 32'd1 : 32'd0);
    chk("match_cnt",    32'(match_cnt),    32'(m_match));
    chk("mismatch_cnt", 32'(mismatch_cnt), 32'(m_mis));
    chk("unexpected",   32'(unexpected),   32'(m_unexp));
    chk("error",        32'(error),        32'(m_err));
    chk("first_exp",    first_exp,         m_fe);
    chk("first_obs",    first_obs,         m_fo);
    chk("state",        32'(state),        32'(m_state));
    chk("match_cnt_w4", 32'(s_match_cnt),  32'(sm));
  endtask

  task automatic step(input logic ev, input logic [31:0] ed,
                      input logic ov, input logic [31:0] od);
    logic             acc;
    logic             fl;
    logic [WIDTH-1:0] h;
    exp_valid = ev;
    exp_data  = ed;
    obs_valid = ov;
    obs_data  = od;
    acc = ev && (q.size() < DEPTH);
    fl  = 1'b0;
    if (ov) begin
      if (q.size() > 0) begin
        h = q.pop_front();
        if (h == od) begin
          m_match++;
        end else begin
          m_mis++;
          fl = 1'b1;
          if (!m_err) begin
            m_fe = h;
            m_fo = od;
          end
        end
      end else begin
        m_unexp = 1'b1;
        fl = 1'b1;
        if (!m_err) begin
          m_fe = '0;
          m_fo = od;
        end
      end
    end
    if (fl)
      m_err = 1'b1;
    if (acc)
      q.push_back(ed);
    if (fl)
      m_state = 2;
    else if (m_state == 0 && (acc || ov))
      m_state = 1;
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Reset with live inputs to show reset overrides a same-cycle push/compare
  task automatic do_reset();
    rst       = 1'b1;
    exp_valid = 1'b1;
    exp_data  = 32'h5555_AAAA;
    obs_valid = 1'b1;
    obs_data  = 32'h1357_9BDF;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    exp_valid = 1'b0;
    obs_valid = 1'b0;
    q.delete();
    m_match = 0;
    m_mis   = 0;
    m_unexp = 1'b0;
    m_err   = 1'b0;
    m_fe    = '0;
    m_fo    = '0;
    m_state = 0;
    check_all();
  endtask

  initial begin
    logic [31:0] w;
    // Basic in-order matches
    do_reset();
    step(1, 32'h0000_0001, 0, 0);
    step(1, 32'hDEAD_BEEF, 0, 0);
    step(1, 32'hFFFF_FFFF, 0, 0);
    step(0, 0, 1, 32'h0000_0001);
    step(0, 0, 1, 32'hDEAD_BEEF);
    step(0, 0, 1, 32'hFFFF_FFFF);
    chk("tp1_match", 32'(match_cnt), 32'd3);
    chk("tp1_state", 32'(state), 32'd1);

    // Mismatch, then a second mismatch must not disturb first_*
    step(1, 32'h1234_5678, 0, 0);
    step(0, 0, 1, 32'h1234_5679);
    chk("tp2_first_exp", first_exp, 32'h1234_5678);
    chk("tp2_first_obs", first_obs, 32'h1234_5679);
    step(1, 32'hAAAA_0001, 0, 0);
    step(0, 0, 1, 32'h0000_0000);
    chk("tp2_first_hold", first_obs, 32'h1234_5679);
    chk("tp2_state", 32'(state), 32'd2);

    // Fill to full, refused push with same-cycle pop, then drain
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      step(1, 32'hC000_0000 + 32'(i), 0, 0);
    chk("tp3_full_ready", 32'(exp_ready), 32'd0);
    step(1, 32'hBAD0_0009, 1, q[0]);
    chk("tp3_level7", 32'(level), 32'd7);
    while (q.size() > 0)
      step(0, 0, 1, q[0]);
    chk("tp3_match", 32'(match_cnt), 32'd8);

    // Unexpected observation in IDLE with a same-cycle push
    do_reset();
    step(1, 32'h0BAD_F00D, 1, 32'hA5A5_A5A5);
    chk("tp4_first_obs", first_obs, 32'hA5A5_A5A5);
    chk("tp4_level", 32'(level), 32'd1);
    step(0, 0, 1, 32'h0BAD_F00D);

    // Streaming with level held at 3, wrapping pointers; small copy saturates
    do_reset();
    for (int i = 0; i < 3; i++)
      step(1, 32'h7000_0000 + 32'(i), 0, 0);
    for (int i = 3; i < 23; i++) begin
      w = q[0];
      step(1, 32'h7000_0000 + 32'(i) * 32'h0101_0101, 1, w);
    end
    chk("tp5_match", 32'(match_cnt), 32'd20);
    chk("tp5_sat", 32'(s_match_cnt), 32'd15);
    while (q.size() > 0)
      step(0, 0, 1, q[0]);

    // Reset mid-operation from FAIL with level 5, then resume
    do_reset();
    for (int i = 0; i < 6; i++)
      step(1, 32'h0F0F_0000 + 32'(i), 0, 0);
    step(0, 0, 1, 32'hFFFF_0000);
    chk("tp6_pre_level", 32'(level), 32'd5);
    do_reset();
    chk("tp6_level", 32'(level), 32'd0);
    chk("tp6_state", 32'(state), 32'd0);
    step(1, 32'h2468_ACE0, 0, 0);
    step(1, 32'h1357_9BDF, 1, 32'h2468_ACE0);
    step(0, 0, 1, 32'h1357_9BDF);
    step(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
